dmem_wait_responder: RTL and testbench

DMEM_WAIT_RESPONDER -- requirements
Module: dmem_wait_responder

---
 rtl/dmem_wait_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_wait_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: single-port data memory for a stalling CPU.
// Each read or write request passes through a configurable number of wait
// states. The request completes with a one-cycle ready pulse. stall tells the
// CPU to hold its clock until the access finishes.
// Optional build macro DMEM_ALIGN_CHECK_EN: when it is defined, a request with
// a misaligned byte address completes as an error. That request sets
// misalign=1, returns rdata=0 and does not write memory.
module dmem_wait_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 6
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        memtoreg,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        misalign
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            count;
  logic [3:0]            count_next;

  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] lat_index;
  logic [31:0]           lat_wdata;
  logic                  lat_write;
  logic                  lat_misalign;

  logic                  request;
  logic                  accept;
  logic                  enter_done;
  logic [DEPTH_LOG2-1:0] live_index;
  logic                  live_misalign;
  logic [DEPTH_LOG2-1:0] commit_index;
  logic [31:0]           commit_wdata;
  logic                  commit_write;
  logic                  commit_misalign;
  logic                  misalign_q;
  logic                  unused_addr_bits;

  assign request    = memtoreg | memwrite;
  assign accept     = (state == IDLE) && request;
  assign live_index = addr[DEPTH_LOG2+1:2];

  // Upper address bits wrap away. The low two bits matter only when the
  // alignment check is built in.
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign live_misalign = (addr[1:0] != 2'b00);
  assign misalign      = misalign_q;
`else
  assign live_misalign = 1'b0;
  assign misalign      = 1'b0;
`endif

  // When WAIT_CYCLES is 0, the accept edge also enters DONE. The live inputs
  // stand in for the latched copies on that edge.
  assign commit_index    = (state == IDLE) ? live_index    : lat_index;
  assign commit_wdata    = (state == IDLE) ? wdata         : lat_wdata;
  assign commit_write    = (state == IDLE) ? memwrite      : lat_write;
  assign commit_misalign = (state == IDLE) ? live_misalign : lat_misalign;

  assign enter_done = (state_next == DONE);

  // The CPU is held while a request waits for acceptance or sits in wait states.
  assign stall = ((state == IDLE) && request) || (state == WAIT);
  assign ready = (state == DONE);

  // Next-state and wait-counter logic for the IDLE -> WAIT -> DONE sequence.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (request) begin
          if (WAIT_INIT == 4'd0) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            count_next = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count <= 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // State register and wait counter. A reset drops any request in flight.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Capture the request on the accept edge so later input changes are ignored.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lat_index    <= '0;
      lat_wdata    <= 32'd0;
      lat_write    <= 1'b0;
      lat_misalign <= 1'b0;
    end else if (accept) begin
      lat_index    <= live_index;
      lat_wdata    <= wdata;
      lat_write    <= memwrite;
      lat_misalign <= live_misalign;
    end
  end

  // Register the completion result. rdata holds until the next completion.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= 32'd0;
      misalign_q <= 1'b0;
    end else if (enter_done) begin
      if (commit_misalign) begin
        rdata      <= 32'd0;
        misalign_q <= 1'b1;
      end else if (commit_write) begin
        rdata      <= commit_wdata;
        misalign_q <= 1'b0;
      end else begin
        rdata      <= mem[commit_index];
        misalign_q <= 1'b0;
      end
    end
  end

  // The memory array is never reset. A write commits only on the edge into DONE.
  always_ff @(posedge clk_in) begin
    if (rst_n && enter_done && commit_write && !commit_misalign) begin
      mem[commit_index] <= commit_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder.
// dut2 uses the default two wait states. dut0 uses zero wait states.
// Only the selected DUT sees the request lines, so each memory's contents stay
// predictable.
module tb_dmem_wait_responder;

  logic        clk_in;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic        sel0;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        memtoreg2, memwrite2, ready2, stall2, misalign2;
  logic        memtoreg0, memwrite0, ready0, stall0, misalign0;
  logic [31:0] rdata2, rdata0;

  logic        cur_ready, cur_stall, cur_mis;
  logic [31:0] cur_rdata;

  int vectors;
  int miscompares;

  assign memtoreg2 = rd & ~sel0;
  assign memwrite2 = wr & ~sel0;
  assign memtoreg0 = rd & sel0;
  assign memwrite0 = wr & sel0;

  assign cur_ready = sel0 ? ready0    : ready2;
  assign cur_stall = sel0 ? stall0    : stall2;
  assign cur_mis   = sel0 ? misalign0 : misalign2;
  assign cur_rdata = sel0 ? rdata0    : rdata2;

  dmem_wait_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) dut2 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .memtoreg (memtoreg2),
    .memwrite (memwrite2),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata2),
    .ready    (ready2),
    .stall    (stall2),
    .misalign (misalign2)
  );

  dmem_wait_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) dut0 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .memtoreg (memtoreg0),
    .memwrite (memwrite0),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata0),
    .ready    (ready0),
    .stall    (stall0),
    .misalign (misalign0)
  );

  // 10-unit free-running clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue a request at the current point, which must be just after a negedge.
  // Measure stall cycles and the cycle in which ready appears, then release
  // the request lines. The caller checks the returned completion data.
  task automatic applyStimulus(input bit use0, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input bit scramble, input int exp_lat,
                               input string tag,
                               output logic [31:0] got_rdata,
                               output logic got_mis);
    int  stalls;
    int  lat;
    bit  seen;
    stalls    = 0;
    lat       = -1;
    seen      = 1'b0;
    got_rdata = 32'hx;
    got_mis   = 1'bx;
    sel0  = use0;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (cur_stall) stalls++;
      if (cur_ready) begin
        seen      = 1'b1;
        lat       = i;
        got_rdata = cur_rdata;
        got_mis   = cur_mis;
        break;
      end
      @(negedge clk_in);
      if (scramble && i == 0) begin
        addr  = ~a;
        wdata = ~d;
      end
      #1;
    end
    rd = 1'b0;
    wr = 1'b0;
    checkOutput({tag, "_ready_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    @(negedge clk_in);
    #1;
    checkOutput({tag, "_ready_width"}, 32'(cur_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic        mis;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    sel0  = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk_in);
    #1;
    checkOutput("rst_ready", 32'(ready2), 32'd0);
    checkOutput("rst_stall", 32'(stall2), 32'd0);
    checkOutput("rst_rdata", rdata2, 32'd0);
    checkOutput("rst_misalign", 32'(misalign2), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    #1;

    // Two wait states: write with inputs scrambled after accept, then read back
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 3, "w2_wr10", got, mis);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 3, "w2_rd10", got, mis);
    checkOutput("w2_rd10_rdata", got, 32'hDEADBEEF);
    checkOutput("w2_rd10_mis", 32'(mis), 32'd0);

    // Zero wait states
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, 1, "w0_wr00", got, mis);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1, "w0_rd00", got, mis);
    checkOutput("w0_rd00_rdata", got, 32'hCAFEF00D);

    // Address wrap modulo 64 words
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h04, 32'h12345678, 1'b0, 3, "wrap_wr04", got, mis);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 3, "wrap_rd104", got, mis);
    checkOutput("wrap_rd104_rdata", got, 32'h12345678);

    // Reset during WAIT aborts the write
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h08, 32'h00000001, 1'b0, 3, "abort_pre", got, mis);
    sel0  = 1'b0;
    wr    = 1'b1;
    addr  = 32'h08;
    wdata = 32'hFFFFFFFF;
    @(negedge clk_in);
    #1;
    checkOutput("abort_in_wait_stall", 32'(stall2), 32'd1);
    wr    = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_async_stall", 32'(stall2), 32'd0);
    checkOutput("abort_async_rdata", rdata2, 32'd0);
    checkOutput("abort_async_ready", 32'(ready2), 32'd0);
    rd   = 1'b1;
    addr = 32'h08;
    @(negedge clk_in);
    #1;
    checkOutput("abort_no_ready", 32'(ready2), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 3, "abort_rd08", got, mis);
    checkOutput("abort_rd08_rdata", got, 32'h00000001);

    // Both request lines high behave as a write
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 3, "both_20", got, mis);
    checkOutput("both_20_rdata", got, 32'hA5A5A5A5);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 3, "both_rd20", got, mis);
    checkOutput("both_rd20_rdata", got, 32'hA5A5A5A5);

    // Misaligned write
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h22, 32'h11112222, 1'b0, 3, "mis_wr22", got, mis);
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput("mis_wr22_flag", 32'(mis), 32'd1);
    checkOutput("mis_wr22_rdata", got, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 3, "mis_rd20", got, mis);
    checkOutput("mis_rd20_rdata", got, 32'hA5A5A5A5);
    checkOutput("mis_rd20_flag", 32'(mis), 32'd0);
`else
    checkOutput("mis_wr22_flag", 32'(mis), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 3, "mis_rd20", got, mis);
    checkOutput("mis_rd20_rdata", got, 32'h11112222);
    checkOutput("mis_rd20_flag", 32'(mis), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
